axis_uart_rx_fifo: RTL and testbench

Parametrised UART receiver with 16x oversampling and a runtime baud divisor. Supports configurable data width, parity mode and stop bits, plus break detection. Received characters and per-character error flags go into an internal first-word-fall-through (FWFT) FIFO, which drains through an AXI-Stream master port. It sits between the board RX pin and the stream fabric.

---
 rtl/axis_uart_rx_fifo_if.sv | 13 +
 rtl/axis_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 tb/tb_axis_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_rx_fifo_if.sv
// AXI-Stream channel carrying received UART characters and their error flags.
// tuser is {break, parity_err, frame_err}.
interface axis_uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tdata;
    logic [2:0]           tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding an FWFT FIFO drained over AXI-Stream.
// Optional idle timeout pulse is built only when UART_RX_TIMEOUT_EN is defined.
module axis_uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        uart_rx,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    axis_uart_rx_fifo_if.master         m_axis,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    output logic                        rx_active,
    output logic                        rx_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 3;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_BITS < 1 ||
        DIV_WIDTH < 1) begin : g_bad_params
        $error("axis_uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

    state_e                 state_q, state_d;
    logic                   rx_s1_q, rx_s2_q, armed_q;
    logic [DIV_WIDTH-1:0]   div_q, div_d, tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]          samp_q, samp_d;
    logic                   s_a_q, s_a_d, s_b_q, s_b_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d, ferr_q, ferr_d, stop_one_q, stop_one_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]            count_q, count_d;
    logic                   overrun_q, overrun_d;

    logic rx_line, start_det, tick, mid, bit_end, maj, last_stop;
    logic push, pop, full, wr_en, brk_now, ferr_now, perr;
    logic [EW-1:0] entry;

    assign rx_line   = rx_s2_q;
    // armed_q keeps a line held low through reset from being taken as a start bit
    assign start_det = (state_q == IDLE) && armed_q && !rx_line;
    assign tick      = (tick_cnt_q == div_q);
    assign mid       = tick && (samp_q == SW'(OVERSAMPLE / 2 + 1));
    assign bit_end   = tick && (samp_q == SW'(OVERSAMPLE - 1));
    assign maj       = (s_a_q & s_b_q) | (s_a_q & rx_line) | (s_b_q & rx_line);
    assign last_stop = (stop_q == 1'(STOP_BITS - 1));

    always_ff @(posedge aclk) begin : state_reg
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_det) state_d = START;
            START:    if (mid && maj) state_d = IDLE;
                      else if (bit_end) state_d = DATA;
            DATA:     if (bit_end && bit_q == BW'(DATA_BITS - 1))
                          state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:   if (bit_end) state_d = STOP;
            STOP:     if (mid && last_stop) state_d = brk_now ? BRK_WAIT : IDLE;
            BRK_WAIT: if (tick && rx_line && samp_q == SW'(OVERSAMPLE - 1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        rx_active = (state_q != IDLE);
        perr      = 1'b0;
        if (PARITY_MODE == 1)      perr = (par_q != ~^shreg_q);
        else if (PARITY_MODE == 2) perr = (par_q != ^shreg_q);
        ferr_now  = ferr_q | ~maj;
        brk_now   = (shreg_q == '0) && (PARITY_MODE == 0 || !par_q) && !stop_one_q && !maj;
        push      = (state_q == STOP) && mid && last_stop;
        entry     = {brk_now, perr, ferr_now, shreg_q};
    end

    always_comb begin : frame_datapath
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_d     = samp_q;
        if (tick) samp_d = (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + 1'b1;
        div_d      = div_q;
        s_a_d      = s_a_q;
        s_b_d      = s_b_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        stop_one_d = stop_one_q;
        if (tick && samp_q == SW'(OVERSAMPLE / 2 - 1)) s_a_d = rx_line;
        if (tick && samp_q == SW'(OVERSAMPLE / 2))     s_b_d = rx_line;
        case (state_q)
            DATA: begin
                if (mid)     shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (bit_end) bit_d   = bit_q + 1'b1;
            end
            PARITY: if (mid) par_d = maj;
            STOP: begin
                if (mid) begin
                    ferr_d     = ferr_q | ~maj;
                    stop_one_d = stop_one_q | maj;
                end
                if (bit_end) stop_d = 1'b1;
            end
            // bit-time of high line is measured from scratch on every low sample
            BRK_WAIT: if (!rx_line) samp_d = '0;
            default: ;
        endcase
        if (push) samp_d = '0;
        if (start_det) begin
            tick_cnt_d = '0;
            samp_d     = '0;
            div_d      = baud_div;
            bit_d      = '0;
            stop_d     = 1'b0;
            par_d      = 1'b0;
            ferr_d     = 1'b0;
            stop_one_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin : frame_regs
        if (!aresetn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            armed_q    <= 1'b0;
            div_q      <= '0;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            s_a_q      <= 1'b1;
            s_b_q      <= 1'b1;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            armed_q    <= armed_q | rx_s2_q;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            s_a_q      <= s_a_d;
            s_b_q      <= s_b_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
        end
    end

    always_comb begin : fifo_ctrl
        pop       = m_axis.tvalid && m_axis.tready;
        full      = (count_q == (AW + 1)'(FIFO_DEPTH));
        wr_en     = push && (!full || pop);
        overrun_d = push && !wr_en;
        wr_d      = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d      = pop ? rd_q + 1'b1 : rd_q;
        count_d   = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end

    always_ff @(posedge aclk) begin : fifo_regs
        if (!aresetn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) mem_q[wr_q] <= entry;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_axis.tvalid = (count_q != '0);
    assign m_axis.tdata  = mem_q[rd_q][DATA_BITS-1:0];
    assign m_axis.tuser  = mem_q[rd_q][EW-1:DATA_BITS];
    assign fifo_count    = count_q;
    assign overrun       = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    logic [SW-1:0] to_samp_q;
    logic [TW-1:0] to_bits_q;
    logic          to_done_q, to_pulse_q;

    always_ff @(posedge aclk) begin : timeout_regs
        if (!aresetn) begin
            to_samp_q  <= '0;
            to_bits_q  <= '0;
            to_done_q  <= 1'b0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= 1'b0;
            if (start_det || pop) begin
                to_samp_q <= '0;
                to_bits_q <= '0;
            end else if (state_q == IDLE && m_axis.tvalid && !to_done_q && tick) begin
                if (to_samp_q == SW'(OVERSAMPLE - 1)) begin
                    to_samp_q <= '0;
                    if (to_bits_q == TW'(TIMEOUT_BITS - 1)) begin
                        to_bits_q  <= '0;
                        to_pulse_q <= 1'b1;
                        to_done_q  <= 1'b1;
                    end else begin
                        to_bits_q <= to_bits_q + 1'b1;
                    end
                end else begin
                    to_samp_q <= to_samp_q + 1'b1;
                end
            end
            if (wr_en || pop) to_done_q <= 1'b0;
        end
    end
    assign rx_timeout = to_pulse_q;
`else
    assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Directed scoreboard bench: an 8N1 receiver with a 4-deep FIFO and an even-parity receiver.
module tb_axis_uart_rx_fifo;
    localparam int          OS      = 16;
    localparam logic [15:0] DIV     = 16'd1;
    localparam int          BIT_CYC = OS * (int'(DIV) + 1);

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic rx_n = 1'b1;
    logic rx_p = 1'b1;
    logic [2:0] cnt_n;
    logic [4:0] cnt_p;
    logic ovr_n, ovr_p, act_n, act_p, to_n, to_p;

    axis_uart_rx_fifo_if #(.DATA_BITS(8)) if_n ();
    axis_uart_rx_fifo_if #(.DATA_BITS(8)) if_p ();

    always #5 aclk = ~aclk;

    axis_uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(OS),
                        .DIV_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_BITS(32)) u_dut_n (
        .aclk(aclk), .aresetn(aresetn), .uart_rx(rx_n), .baud_div(DIV), .m_axis(if_n),
        .fifo_count(cnt_n), .overrun(ovr_n), .rx_active(act_n), .rx_timeout(to_n));

    axis_uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(OS),
                        .DIV_WIDTH(16), .FIFO_DEPTH(16), .TIMEOUT_BITS(32)) u_dut_p (
        .aclk(aclk), .aresetn(aresetn), .uart_rx(rx_p), .baud_div(DIV), .m_axis(if_p),
        .fifo_count(cnt_p), .overrun(ovr_p), .rx_active(act_p), .rx_timeout(to_p));

    int n_pass = 0;
    int n_total = 0;
    int n_ovr = 0, n_to = 0, n_ovr_p = 0, n_to_p = 0;
    logic [10:0] q_n[$];
    logic [10:0] q_p[$];
    logic [10:0] e_n, e_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] mk(input logic [2:0] u, input logic [7:0] d);
        return {u, d};
    endfunction

    // Scoreboards pop on every accepted beat
    always @(negedge aclk) begin
        if (aresetn && if_n.tvalid && if_n.tready) begin
            check("pop_expected_n", 32'(q_n.size() != 0), 32'd1);
            if (q_n.size() != 0) begin
                e_n = q_n.pop_front();
                check("entry_n", 32'({if_n.tuser, if_n.tdata}), 32'(e_n));
            end
        end
        if (aresetn && if_p.tvalid && if_p.tready) begin
            check("pop_expected_p", 32'(q_p.size() != 0), 32'd1);
            if (q_p.size() != 0) begin
                e_p = q_p.pop_front();
                check("entry_p", 32'({if_p.tuser, if_p.tdata}), 32'(e_p));
            end
        end
        if (ovr_n) n_ovr++;
        if (to_n) n_to++;
        if (ovr_p) n_ovr_p++;
        if (to_p) n_to_p++;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic send_bit(input int sel, input logic b);
        if (sel == 0) rx_n = b;
        else          rx_p = b;
        steps(BIT_CYC);
    endtask

    task automatic send_char(input int sel, input logic [7:0] d, input logic par_en, input logic par);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (par_en) send_bit(sel, par);
        send_bit(sel, 1'b1);
    endtask

    task automatic wait_empty(input int sel, input string tag);
        int k = 0;
        while (((sel == 0) ? q_n.size() : q_p.size()) != 0 && k < 4000) begin
            step();
            k++;
        end
        check(tag, 32'((sel == 0) ? q_n.size() : q_p.size()), 32'd0);
        step();
        check({tag, "_count"}, 32'((sel == 0) ? 32'(cnt_n) : 32'(cnt_p)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ovr0, to0;
        if_n.tready = 1'b1;
        if_p.tready = 1'b1;
        steps(5);
        check("rst_tvalid", 32'(if_n.tvalid), 32'd0);
        check("rst_count", 32'(cnt_n), 32'd0);
        check("rst_overrun", 32'(ovr_n), 32'd0);
        check("rst_active", 32'(act_n), 32'd0);
        check("rst_tdata", 32'(if_n.tdata), 32'd0);
        check("rst_tuser", 32'(if_n.tuser), 32'd0);
        check("rst_timeout", 32'(to_n), 32'd0);
        aresetn = 1'b1;
        steps(4);

        // Basic 8N1: stop-bit majority tick commits on edge 311, tvalid visible after it
        q_n.push_back(mk(3'b000, 8'hA5));
        fork
            send_char(0, 8'hA5, 1'b0, 1'b0);
            begin
                steps(310);
                check("tvalid_before_write", 32'(if_n.tvalid), 32'd0);
                step();
                check("tvalid_after_write", 32'(if_n.tvalid), 32'd1);
            end
        join
        wait_empty(0, "drain_basic");
        check("active_after_frame", 32'(act_n), 32'd0);

        // Even parity: 0x03 expects parity bit 0
        q_p.push_back(mk(3'b010, 8'h03));
        send_char(1, 8'h03, 1'b1, 1'b1);
        q_p.push_back(mk(3'b000, 8'h03));
        send_char(1, 8'h03, 1'b1, 1'b0);
        wait_empty(1, "drain_parity");

        // One-tick low glitch: false start
        rx_n = 1'b0;
        steps(2);
        rx_n = 1'b1;
        steps(3);
        check("glitch_active_high", 32'(act_n), 32'd1);
        steps(40);
        check("glitch_active_low", 32'(act_n), 32'd0);
        check("glitch_no_entry", 32'(cnt_n), 32'd0);

        // One-tick high glitch in the middle of data bit 3
        q_n.push_back(mk(3'b000, 8'h00));
        fork
            send_char(0, 8'h00, 1'b0, 1'b0);
            begin
                steps(4 * BIT_CYC + BIT_CYC / 2);
                rx_n = 1'b1;
                steps(2);
                rx_n = 1'b0;
            end
        join
        wait_empty(0, "drain_data_glitch");

        // Break: 20 bit-times low, then a normal frame
        q_n.push_back(mk(3'b101, 8'h00));
        rx_n = 1'b0;
        steps(20 * BIT_CYC);
        rx_n = 1'b1;
        steps(3 * BIT_CYC);
        q_n.push_back(mk(3'b000, 8'h3C));
        send_char(0, 8'h3C, 1'b0, 1'b0);
        wait_empty(0, "drain_break");

        // Overrun: fifth character dropped
        if_n.tready = 1'b0;
        ovr0 = n_ovr;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q_n.push_back(mk(3'b000, 8'(i)));
            send_char(0, 8'(i), 1'b0, 1'b0);
        end
        check("overrun_count_full", 32'(cnt_n), 32'd4);
        check("overrun_pulses", 32'(n_ovr - ovr0), 32'd1);
        if_n.tready = 1'b1;
        wait_empty(0, "drain_overrun");

        // Pop coincides with the write into a full FIFO
        if_n.tready = 1'b0;
        ovr0 = n_ovr;
        for (int i = 8'h11; i <= 8'h14; i++) begin
            q_n.push_back(mk(3'b000, 8'(i)));
            send_char(0, 8'(i), 1'b0, 1'b0);
        end
        check("coincide_full", 32'(cnt_n), 32'd4);
        q_n.push_back(mk(3'b000, 8'h15));
        fork
            send_char(0, 8'h15, 1'b0, 1'b0);
            begin
                steps(310);
                if_n.tready = 1'b1;
                step();
                if_n.tready = 1'b0;
            end
        join
        check("coincide_no_overrun", 32'(n_ovr - ovr0), 32'd0);
        check("coincide_count", 32'(cnt_n), 32'd4);
        if_n.tready = 1'b1;
        wait_empty(0, "drain_coincide");

        // Idle timeout with an undrained character
        if_n.tready = 1'b0;
        to0 = n_to;
        q_n.push_back(mk(3'b000, 8'h5A));
        send_char(0, 8'h5A, 1'b0, 1'b0);
        steps(40 * BIT_CYC);
`ifdef UART_RX_TIMEOUT_EN
        check("timeout_pulses", 32'(n_to - to0), 32'd1);
`else
        check("timeout_pulses", 32'(n_to - to0), 32'd0);
`endif
        if_n.tready = 1'b1;
        wait_empty(0, "drain_timeout");

        check("p_overrun_none", 32'(n_ovr_p), 32'd0);
        check("p_timeout_none", 32'(n_to_p), 32'd0);
        check("p_active_idle", 32'(act_p), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
